pipe_datapath: RTL

PIPE_DATAPATH -- requirements
Module: pipe_datapath

---
 rtl/pipe_datapath_if.sv | 36 +++
 rtl/pipe_datapath.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_datapath_if.sv
// Operation issue, result and debug signals of pipe_datapath.
// The master drives operations; the slave (the datapath) returns results.
interface pipe_datapath_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNTW  = 32
);
    localparam int unsigned RW = $clog2(NREGS);

    logic            in_valid;
    logic [RW-1:0]   read_reg_num1;
    logic [RW-1:0]   read_reg_num2;
    logic [RW-1:0]   write_reg;
    logic [3:0]      alu_control;
    logic            regwrite;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   dbg_reg_num;
    logic [XLEN-1:0] dbg_data;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            zero_flag;
    logic [CNTW-1:0] retired_count;

    modport master (
        output in_valid, read_reg_num1, read_reg_num2, write_reg, alu_control,
               regwrite, use_imm, imm, dbg_reg_num,
        input  dbg_data, out_valid, result, zero_flag, retired_count
    );

    modport slave (
        input  in_valid, read_reg_num1, read_reg_num2, write_reg, alu_control,
               regwrite, use_imm, imm, dbg_reg_num,
        output dbg_data, out_valid, result, zero_flag, retired_count
    );
endinterface

// File: rtl/pipe_datapath.sv
// Three-stage ID -> EX -> WB integer datapath with a register file and
// EX/WB operand forwarding so dependent operations issue back to back.
module pipe_datapath #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNTW  = 32
) (
    input  logic           clock,
    input  logic           reset,
    pipe_datapath_if.slave bus
);
    localparam int unsigned RW  = $clog2(NREGS);
    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSll  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1010;

    logic [XLEN-1:0] regs_q [NREGS];

    logic            ex_valid_q;
    logic            ex_regwrite_q;
    logic [RW-1:0]   ex_write_reg_q;
    logic [3:0]      ex_alu_control_q;
    logic [XLEN-1:0] ex_a_q;
    logic [XLEN-1:0] ex_b_q;

    logic            wb_valid_q;
    logic            wb_regwrite_q;
    logic            wb_zero_q;
    logic [RW-1:0]   wb_write_reg_q;
    logic [XLEN-1:0] wb_result_q;
    logic [CNTW-1:0] retired_q;

    logic            ex_fwd_ok;
    logic            wb_commit;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    assign ex_fwd_ok = ex_valid_q && ex_regwrite_q && (ex_write_reg_q != '0);
    assign wb_commit = wb_valid_q && wb_regwrite_q && (wb_write_reg_q != '0);
    assign shamt     = ex_b_q[SHW-1:0];

    always_comb begin
        alu_out = '0;
        case (ex_alu_control_q)
            OpAnd:   alu_out = ex_a_q & ex_b_q;
            OpOr:    alu_out = ex_a_q | ex_b_q;
            OpAdd:   alu_out = ex_a_q + ex_b_q;
            OpSub:   alu_out = ex_a_q - ex_b_q;
            OpXor:   alu_out = ex_a_q ^ ex_b_q;
            OpSll:   alu_out = ex_a_q << shamt;
            OpSrl:   alu_out = ex_a_q >> shamt;
            OpSra:   alu_out = $unsigned($signed(ex_a_q) >>> shamt);
            OpSlt:   alu_out = {{(XLEN-1){1'b0}}, $signed(ex_a_q) < $signed(ex_b_q)};
            OpSltu:  alu_out = {{(XLEN-1){1'b0}}, ex_a_q < ex_b_q};
            default: alu_out = '0;
        endcase
    end

    // The EX/WB entry is written on the same edge that captures the operands,
    // so it must be forwarded rather than read from the register file.
    always_comb begin
        op_a = regs_q[bus.read_reg_num1];
        if (bus.read_reg_num1 != '0) begin
            if (ex_fwd_ok && (ex_write_reg_q == bus.read_reg_num1)) begin
                op_a = alu_out;
            end else if (wb_commit && (wb_write_reg_q == bus.read_reg_num1)) begin
                op_a = wb_result_q;
            end
        end
    end

    always_comb begin
        op_b = regs_q[bus.read_reg_num2];
        if (bus.use_imm) begin
            op_b = bus.imm;
        end else if (bus.read_reg_num2 != '0) begin
            if (ex_fwd_ok && (ex_write_reg_q == bus.read_reg_num2)) begin
                op_b = alu_out;
            end else if (wb_commit && (wb_write_reg_q == bus.read_reg_num2)) begin
                op_b = wb_result_q;
            end
        end
    end

    // Register 0 is never written, so it reads 0 without extra muxing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_commit) begin
            regs_q[wb_write_reg_q] <= wb_result_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid_q       <= 1'b0;
            ex_regwrite_q    <= 1'b0;
            ex_write_reg_q   <= '0;
            ex_alu_control_q <= '0;
            ex_a_q           <= '0;
            ex_b_q           <= '0;
        end else begin
            ex_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                ex_regwrite_q    <= bus.regwrite;
                ex_write_reg_q   <= bus.write_reg;
                ex_alu_control_q <= bus.alu_control;
                ex_a_q           <= op_a;
                ex_b_q           <= op_b;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_write_reg_q <= '0;
            wb_result_q    <= '0;
            wb_zero_q      <= 1'b0;
        end else begin
            wb_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                wb_regwrite_q  <= ex_regwrite_q;
                wb_write_reg_q <= ex_write_reg_q;
                wb_result_q    <= alu_out;
                wb_zero_q      <= (alu_out == '0);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (wb_commit) begin
            retired_q <= retired_q + CNTW'(1);
        end
    end

    assign bus.dbg_data      = regs_q[bus.dbg_reg_num];
    assign bus.out_valid     = wb_valid_q;
    assign bus.result        = wb_result_q;
    assign bus.zero_flag     = wb_zero_q;
    assign bus.retired_count = retired_q;
endmodule
